// File: rtl/adc_pkt_pkg.sv
// Shared definitions for the ADC frame packer: sync byte, header length,
// FSM state encoding and the header byte lookup.
package adc_pkt_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam int         HDR_LEN   = 4;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        FETCH,
        LOAD,
        HI,
        LO,
        CSUM
    } state_t;

    // Header byte i: sync, channel, seq high, seq low.
    function automatic logic [7:0] hdr_byte(
        input logic [1:0]  idx,
        input logic [1:0]  ch,
        input logic [15:0] seq
    );
        logic [7:0] b;
        case (idx)
            2'd0:    b = SYNC_BYTE;
            2'd1:    b = {6'b0, ch};
            2'd2:    b = seq[15:8];
            default: b = seq[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/adc_pkt_xor.sv
// 8-bit XOR accumulator used for the optional frame checksum.
// Ports: i_clock, i_reset (async high), i_clr, i_en, i_data -> o_acc.
module adc_pkt_xor
    import adc_pkt_pkg::*;
(
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_clr,
    input  logic       i_en,
    input  logic [7:0] i_data,
    output logic [7:0] o_acc
);

    logic [7:0] r_acc;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_acc <= 8'h00;
        end else if (i_clr) begin
            r_acc <= 8'h00;
        end else if (i_en) begin
            r_acc <= r_acc ^ i_data;
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/adc_frame_packer.sv
// Packs 16-bit ADC samples from the sample FIFO into framed byte stream:
// 4-byte header (A5, channel, seq hi, seq lo) then samples MSB first.
// Ports: clock, reset (async high), enable, channel, fifo_empty/fifo_dout
// in, fifo_rd out; tx_data/tx_valid/tx_sof/tx_eof out, tx_ready in; busy.
// Build option PACKER_CHECKSUM_EN appends an XOR checksum byte per frame.
module adc_frame_packer
    import adc_pkt_pkg::*;
#(
    parameter int SAMPLES_PER_FRAME = 64,
    parameter int SEQ_BITS          = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic [1:0]  channel,
    input  logic        fifo_empty,
    input  logic [15:0] fifo_dout,
    output logic        fifo_rd,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        tx_sof,
    output logic        tx_eof,
    output logic        busy
);

    state_t              r_state;
    logic [1:0]          r_idx;
    logic [7:0]          r_cnt;
    logic [SEQ_BITS-1:0] r_seq;
    logic [1:0]          r_ch;
    logic [15:0]         r_sample;

    logic                w_xfer;
    logic                w_last;
    logic [15:0]         w_seq16;

    assign w_xfer  = tx_valid && tx_ready;
    assign w_last  = (r_cnt == 8'(SAMPLES_PER_FRAME - 1));
    assign w_seq16 = 16'(r_seq);
    assign busy    = (r_state != IDLE);

`ifdef PACKER_CHECKSUM_EN
    logic [7:0] w_csum;
    logic       w_acc_clr;
    logic       w_acc_en;

    // Accumulator restarts while idle and folds in every byte but its own.
    assign w_acc_clr = (r_state == IDLE);
    assign w_acc_en  = w_xfer && (r_state != CSUM);

    adc_pkt_xor u_xor (
        .i_clock (clock),
        .i_reset (reset),
        .i_clr   (w_acc_clr),
        .i_en    (w_acc_en),
        .i_data  (tx_data),
        .o_acc   (w_csum)
    );
`endif

    // Outputs decode straight from registered state so reset clears them
    // asynchronously and they cannot change during a stall.
    always_comb begin
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        tx_sof   = 1'b0;
        tx_eof   = 1'b0;
        fifo_rd  = 1'b0;
        case (r_state)
            HDR: begin
                tx_valid = 1'b1;
                tx_data  = hdr_byte(r_idx, r_ch, w_seq16);
                tx_sof   = (r_idx == 2'd0);
            end
            FETCH: begin
                fifo_rd = !fifo_empty;
            end
            HI: begin
                tx_valid = 1'b1;
                tx_data  = r_sample[15:8];
            end
            LO: begin
                tx_valid = 1'b1;
                tx_data  = r_sample[7:0];
`ifndef PACKER_CHECKSUM_EN
                tx_eof   = w_last;
`endif
            end
`ifdef PACKER_CHECKSUM_EN
            CSUM: begin
                tx_valid = 1'b1;
                tx_data  = w_csum;
                tx_eof   = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_idx    <= 2'd0;
            r_cnt    <= 8'd0;
            r_seq    <= '0;
            r_ch     <= 2'd0;
            r_sample <= 16'h0000;
        end else begin
            case (r_state)
                IDLE: begin
                    if (enable && !fifo_empty) begin
                        r_ch    <= channel;
                        r_idx   <= 2'd0;
                        r_cnt   <= 8'd0;
                        r_state <= HDR;
                    end
                end
                HDR: begin
                    if (w_xfer) begin
                        if (r_idx == 2'(HDR_LEN - 1)) begin
                            r_state <= FETCH;
                        end else begin
                            r_idx <= r_idx + 2'd1;
                        end
                    end
                end
                FETCH: begin
                    if (!fifo_empty) begin
                        r_state <= LOAD;
                    end
                end
                LOAD: begin
                    r_sample <= fifo_dout;
                    r_state  <= HI;
                end
                HI: begin
                    if (w_xfer) begin
                        r_state <= LO;
                    end
                end
                LO: begin
                    if (w_xfer) begin
                        if (w_last) begin
`ifdef PACKER_CHECKSUM_EN
                            r_state <= CSUM;
`else
                            r_seq   <= r_seq + 1'b1;
                            r_state <= IDLE;
`endif
                        end else begin
                            r_cnt   <= r_cnt + 8'd1;
                            r_state <= FETCH;
                        end
                    end
                end
`ifdef PACKER_CHECKSUM_EN
                CSUM: begin
                    if (w_xfer) begin
                        r_seq   <= r_seq + 1'b1;
                        r_state <= IDLE;
                    end
                end
`endif
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_frame_packer.sv
// Directed scoreboard bench for adc_frame_packer (4 samples/frame, 2-bit seq).
// Expected bytes are queued at stimulus time and checked on each transfer.
module tb_adc_frame_packer;

    typedef struct packed {
        logic [7:0] d;
        logic       sof;
        logic       eof;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic [1:0]  channel;
    logic        fifo_empty;
    logic [15:0] fifo_dout;
    logic        fifo_rd;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        tx_sof;
    logic        tx_eof;
    logic        busy;

    int n_assert = 0;
    int n_fail   = 0;
    int n_bytes  = 0;
    int rd_cnt   = 0;

    exp_t sb[$];

    logic [15:0] fmem[256];
    int          wr_ptr = 0;
    int          rd_ptr = 0;

    always #5 clock = ~clock;

    adc_frame_packer #(
        .SAMPLES_PER_FRAME (4),
        .SEQ_BITS          (2)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .channel    (channel),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_rd    (fifo_rd),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_sof     (tx_sof),
        .tx_eof     (tx_eof),
        .busy       (busy)
    );

    // FIFO model: read data appears the cycle after fifo_rd.
    assign fifo_empty = (rd_ptr == wr_ptr);

    always @(posedge clock) begin
        if (fifo_rd && (rd_ptr != wr_ptr)) begin
            fifo_dout <= fmem[rd_ptr[7:0]];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic fpush(input logic [15:0] v);
        fmem[wr_ptr[7:0]] = v;
        wr_ptr++;
    endtask

    task automatic push_frame(input logic [1:0] ch, input logic [1:0] seq,
                              input logic [15:0] a, input logic [15:0] b,
                              input logic [15:0] c, input logic [15:0] d,
                              input int n);
        logic [7:0] f[13];
        int         len;
        f[0]  = 8'hA5;
        f[1]  = {6'b0, ch};
        f[2]  = 8'h00;
        f[3]  = {6'b0, seq};
        f[4]  = a[15:8];
        f[5]  = a[7:0];
        f[6]  = b[15:8];
        f[7]  = b[7:0];
        f[8]  = c[15:8];
        f[9]  = c[7:0];
        f[10] = d[15:8];
        f[11] = d[7:0];
        len   = 12;
`ifdef PACKER_CHECKSUM_EN
        f[12] = 8'h00;
        for (int i = 0; i < 12; i++) f[12] = f[12] ^ f[i];
        len = 13;
`endif
        for (int i = 0; i < len && i < n; i++)
            sb.push_back({f[i], (i == 0), (i == len - 1)});
    endtask

    task automatic wait_done(input int budget, input int mode,
                             input string tag);
        logic [3:0] pat;
        int         k;
        pat = 4'b1001;
        k   = 0;
        while ((sb.size() != 0 || busy) && k < budget) begin
            tx_ready = (mode == 1) ? pat[k % 4] : 1'b1;
            tick();
            k++;
        end
        tx_ready = 1'b1;
        chk({tag, "_done"}, 32'(k < budget), 1);
    endtask

    initial begin
        int         base;
        int         rd0;
        int         k;
        logic       prev_stall;
        logic [9:0] held;

        reset    = 1'b1;
        enable   = 1'b0;
        channel  = 2'd0;
        tx_ready = 1'b1;

        fork
            begin
                prev_stall = 1'b0;
                held       = '0;
                forever begin
                    exp_t e;
                    @(negedge clock);
                    if (prev_stall) begin
                        chk("stall_valid", 32'(tx_valid), 1);
                        chk("stall_hold", {22'b0, tx_data, tx_sof, tx_eof},
                            {22'b0, held});
                    end
                    if (fifo_rd) begin
                        chk("rd_while_empty", 32'(fifo_empty), 0);
                        rd_cnt++;
                    end
                    if (tx_valid && tx_ready) begin
                        if (sb.size() == 0) begin
                            chk("extra_byte", sb.size(), 1);
                        end else begin
                            e = sb.pop_front();
                            chk($sformatf("byte%0d", n_bytes),
                                {22'b0, tx_data, tx_sof, tx_eof},
                                {22'b0, e});
                        end
                        n_bytes++;
                    end
                    prev_stall = tx_valid && !tx_ready && !reset;
                    held       = {tx_data, tx_sof, tx_eof};
                end
            end
        join_none

        // Reset state
        tick();
        tick();
        chk("rst_valid", 32'(tx_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_outs", {21'b0, fifo_rd, tx_data, tx_sof, tx_eof}, 0);
        reset = 1'b0;
        tick();
        chk("idle_busy", 32'(busy), 0);

        // Basic frame, channel 2, seq 0
        rd0 = rd_cnt;
        fpush(16'h1234); fpush(16'hABCD); fpush(16'h0001); fpush(16'hFFFF);
        push_frame(2'd2, 2'd0, 16'h1234, 16'hABCD, 16'h0001, 16'hFFFF, 99);
        channel = 2'd2;
        enable  = 1'b1;
        wait_done(200, 0, "basic");
        chk("basic_rd", rd_cnt - rd0, 4);

        // Same data with backpressure 1,0,0,1
        rd0 = rd_cnt;
        fpush(16'h1234); fpush(16'hABCD); fpush(16'h0001); fpush(16'hFFFF);
        push_frame(2'd2, 2'd1, 16'h1234, 16'hABCD, 16'h0001, 16'hFFFF, 99);
        wait_done(400, 1, "stall");
        chk("stall_rd", rd_cnt - rd0, 4);

        // Underflow mid-frame
        rd0 = rd_cnt;
        fpush(16'h0102); fpush(16'h0304);
        push_frame(2'd2, 2'd2, 16'h0102, 16'h0304, 16'h0506, 16'h0708, 99);
        for (int i = 0; i < 20; i++) tick();
        chk("uf_valid", 32'(tx_valid), 0);
        chk("uf_busy", 32'(busy), 1);
        chk("uf_rd", rd_cnt - rd0, 2);
        fpush(16'h0506); fpush(16'h0708);
        wait_done(200, 0, "uf");
        chk("uf_rd_total", rd_cnt - rd0, 4);

        // Back-to-back frames across the seq wrap (3 -> 0)
        rd0 = rd_cnt;
        for (int i = 0; i < 8; i++) fpush(16'(16'hC000 + i));
        push_frame(2'd2, 2'd3, 16'hC000, 16'hC001, 16'hC002, 16'hC003, 99);
        push_frame(2'd2, 2'd0, 16'hC004, 16'hC005, 16'hC006, 16'hC007, 99);
        wait_done(400, 0, "wrap");
        chk("wrap_rd", rd_cnt - rd0, 8);

        // Reset during HI of sample 1 (frame seq 1)
        base = n_bytes;
        fpush(16'h1111); fpush(16'h2222); fpush(16'h3333); fpush(16'h4444);
        push_frame(2'd2, 2'd1, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 6);
        k = 0;
        while (!(n_bytes == base + 6 && tx_valid) && k < 100) begin
            tick();
            k++;
        end
        chk("hi_reached", 32'(k < 100), 1);
        chk("hi_s1_data", 32'(tx_data), 32'h22);
        reset = 1'b1;
        #1;
        chk("arst_valid", 32'(tx_valid), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_sb", sb.size(), 0);
        fpush(16'h5555); fpush(16'h6666);
        push_frame(2'd2, 2'd0, 16'h3333, 16'h4444, 16'h5555, 16'h6666, 99);
        tick();
        tick();
        reset = 1'b0;
        wait_done(200, 0, "post_rst");

        // Enable drop and channel change mid-frame (seq 1)
        rd0     = rd_cnt;
        base    = n_bytes;
        channel = 2'd0;
        fpush(16'h0A0B); fpush(16'h0C0D); fpush(16'h0E0F); fpush(16'h1020);
        push_frame(2'd0, 2'd1, 16'h0A0B, 16'h0C0D, 16'h0E0F, 16'h1020, 99);
        k = 0;
        while (n_bytes < base + 4 && k < 100) begin
            tick();
            k++;
        end
        chk("hdr_sent", 32'(k < 100), 1);
        enable  = 1'b0;
        channel = 2'd3;
        wait_done(200, 0, "en_drop");
        chk("en_drop_rd", rd_cnt - rd0, 4);
        fpush(16'h7777);
        for (int i = 0; i < 20; i++) tick();
        chk("no_start_busy", 32'(busy), 0);
        chk("no_start_rd", rd_cnt - rd0, 4);
        chk("final_sb", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
